// File: rtl/sfp_mac_pkg.sv
// Shared types and helpers for the pipelined sfp multiply-accumulate.
// Tag bundle travels alongside each product through the multiplier stages.
package sfp_mac_pkg;

   localparam int MULT_STAGES_MAX = 4;

   typedef struct packed {
      logic valid;
      logic sub;
      logic last;
   } tag_t;

   // Sign-overflow of an effective add, from operand and result sign bits
   function automatic logic acc_ovf(input logic a, input logic b, input logic sum);
      return (a == b) && (sum != a);
   endfunction

endpackage

// File: rtl/sfp.sv
// Signed fixed-point value bundle: iw integer bits, qw fraction bits.
// The in/out modports give the direction at each block boundary.
interface sfp #(
   parameter int iw = 1,
   parameter int qw = 0
);
   logic signed [iw+qw-1:0] val;

   modport in  (input  val);
   modport out (output val);
endinterface

// File: rtl/sfp_mult_pipe.sv
// Full-width sfp multiply followed by STAGES enabled product registers.
// The tag bundle is delayed in lockstep so valid/sub/last stay aligned.
module sfp_mult_pipe
   import sfp_mac_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int PW     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   sfp.in                       in1,
   sfp.in                       in2,
   input  tag_t                 in_tag,
   output logic signed [PW-1:0] prod,
   output tag_t                 out_tag
);

   logic signed [PW-1:0] mul;
   logic signed [PW-1:0] prod_q [STAGES];
   tag_t                 tag_q  [STAGES];

   assign mul = PW'(in1.val) * PW'(in2.val);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
      end else if (en) begin
         prod_q[0] <= mul;
         tag_q[0]  <= in_tag;
         for (int i = 1; i < STAGES; i++) begin
            prod_q[i] <= prod_q[i-1];
            tag_q[i]  <= tag_q[i-1];
         end
      end
   end

   assign prod    = prod_q[STAGES-1];
   assign out_tag = tag_q[STAGES-1];

endmodule

// File: rtl/sfp_mac_pipe.sv
// Pipelined full-precision signed MAC over framed sample streams.
// Frame sums load the output register and restart the accumulator in one edge.
module sfp_mac_pipe
   import sfp_mac_pkg::*;
#(
   parameter int MULT_STAGES = 2,
   parameter int ACC_GUARD   = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   sfp.in                   in1,
   sfp.in                   in2,
   input  logic             in_sub,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   sfp.out                  out,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int IW1 = in1.iw;
   localparam int QW1 = in1.qw;
   localparam int IW2 = in2.iw;
   localparam int QW2 = in2.qw;
   localparam int OIW = out.iw;
   localparam int OQW = out.qw;
   localparam int PW  = IW1 + QW1 + IW2 + QW2;
   localparam int AW  = OIW + OQW;

   if (OIW != IW1 + IW2 + ACC_GUARD || OQW != QW1 + QW2) begin : g_bad_fmt
      $error("sfp_mac_pipe: out format must be (iw1+iw2+ACC_GUARD, qw1+qw2)");
   end
   if (MULT_STAGES < 1 || MULT_STAGES > MULT_STAGES_MAX) begin : g_bad_stages
      $error("sfp_mac_pipe: MULT_STAGES out of range 1..4");
   end

   logic                 stall;
   logic                 fire;
   tag_t                 in_tag;
   tag_t                 p_tag;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] ext;
   logic signed [AW-1:0] addend;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_nxt;
   logic                 ovf;
   logic                 ovf_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;

   // in_ready is combinational from out_ready so a pop frees the pipe at once
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign in_tag   = '{valid: in_valid && in_ready, sub: in_sub, last: in_last};

   sfp_mult_pipe #(
      .STAGES (MULT_STAGES),
      .PW     (PW)
   ) u_mult (
      .clk     (clk),
      .rst     (rst),
      .en      (!stall),
      .in1     (in1),
      .in2     (in2),
      .in_tag  (in_tag),
      .prod    (prod),
      .out_tag (p_tag)
   );

   assign fire    = p_tag.valid && !stall;
   assign ext     = AW'(prod);
   assign addend  = p_tag.sub ? -ext : ext;
   assign acc_nxt = acc + addend;
   assign ovf_nxt = ovf | acc_ovf(acc[AW-1], addend[AW-1], acc_nxt[AW-1]);
   assign cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         ovf       <= 1'b0;
         cnt       <= '0;
         out.val   <= '0;
         out_ovf   <= 1'b0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (fire && p_tag.last) begin
            out.val   <= acc_nxt;
            out_ovf   <= ovf_nxt;
            out_count <= cnt_nxt;
            out_valid <= 1'b1;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
         end else if (fire) begin
            acc <= acc_nxt;
            ovf <= ovf_nxt;
            cnt <= cnt_nxt;
         end
      end
   end

endmodule

// File: tb/tb_sfp_mac_pipe.sv
// Scoreboard bench: three DUTs (MULT_STAGES 2, 1, 4) with sfp(2,2) inputs
// and sfp(7,4) sums, checked against an integer frame-sum reference model.
module tb_sfp_mac_pipe;

   typedef struct {
      int val;
      bit ovf;
      int cnt;
   } exp_t;

   localparam int AW   = 11;
   localparam int MINV = -(1 << (AW - 1));
   localparam int MAXV = (1 << (AW - 1)) - 1;

   logic clk;
   int   checks;
   int   errors;

   logic              rst_v [3];
   logic signed [3:0] a_v   [3];
   logic signed [3:0] b_v   [3];
   logic              sub_v [3];
   logic              lst_v [3];
   logic              vld   [3];
   logic              ordy  [3];
   bit                rmode [3];
   logic              rdy   [3];
   logic              ov    [3];
   logic              oovf  [3];
   int                o_val [3];
   int                o_cnt [3];

   exp_t exp_q [3][$];
   int   lat_q [3][$];

   int run_w   [3];
   bit run_ovf [3];
   int run_cnt [3];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MS = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      localparam int CW = (g == 2) ? 3 : 16;

      sfp #(.iw(2), .qw(2)) ia ();
      sfp #(.iw(2), .qw(2)) ib ();
      sfp #(.iw(7), .qw(4)) io ();

      logic          rdy_w;
      logic          ov_w;
      logic          ovf_w;
      logic [CW-1:0] cnt_w;

      assign ia.val   = a_v[g];
      assign ib.val   = b_v[g];
      assign rdy[g]   = rdy_w;
      assign ov[g]    = ov_w;
      assign oovf[g]  = ovf_w;
      assign o_val[g] = int'(io.val);
      assign o_cnt[g] = int'(cnt_w);

      sfp_mac_pipe #(
         .MULT_STAGES (MS),
         .ACC_GUARD   (3),
         .CNT_W       (CW)
      ) dut (
         .clk       (clk),
         .rst       (rst_v[g]),
         .in1       (ia),
         .in2       (ib),
         .in_sub    (sub_v[g]),
         .in_last   (lst_v[g]),
         .in_valid  (vld[g]),
         .in_ready  (rdy_w),
         .out       (io),
         .out_ovf   (ovf_w),
         .out_count (cnt_w),
         .out_valid (ov_w),
         .out_ready (ordy[g])
      );

      // act counts non-stalled cycles; a result must appear MS+1 of them
      // after its last sample was accepted
      int   act;
      int   acc_at;
      logic prev_v;
      logic prev_hs;
      exp_t e;

      initial begin
         act     = 0;
         prev_v  = 1'b0;
         prev_hs = 1'b0;
      end

      always @(negedge clk) begin
         if (rst_v[g] === 1'b1) begin
            lat_q[g].delete();
            prev_v  = 1'b0;
            prev_hs = 1'b0;
         end else begin
            if (vld[g] && rdy[g] && lst_v[g]) lat_q[g].push_back(act);
            if (ov[g] && (!prev_v || prev_hs)) begin
               checks++;
               if (lat_q[g].size() == 0) begin
                  errors++;
                  $display("FAIL latency[%0d]: result with no accepted last sample", g);
               end else begin
                  acc_at = lat_q[g].pop_front();
                  if (act - acc_at != MS + 1) begin
                     errors++;
                     $display("FAIL latency[%0d]: got %0d active cycles, expected %0d",
                              g, act - acc_at, MS + 1);
                  end
               end
            end
            if (ov[g] && ordy[g]) begin
               checks++;
               if (exp_q[g].size() == 0) begin
                  errors++;
                  $display("FAIL result[%0d]: unexpected result val=%0d", g, o_val[g]);
               end else begin
                  e = exp_q[g].pop_front();
                  if (o_val[g] != e.val || oovf[g] != e.ovf || o_cnt[g] != e.cnt) begin
                     errors++;
                     $display("FAIL result[%0d]: got val=%0d ovf=%0b cnt=%0d, expected val=%0d ovf=%0b cnt=%0d",
                              g, o_val[g], oovf[g], o_cnt[g], e.val, e.ovf, e.cnt);
                  end
               end
            end
            prev_v  = ov[g];
            prev_hs = ov[g] && ordy[g];
            if (!(ov[g] && !ordy[g])) act++;
         end
      end
   end

   function automatic int wrap(input int t);
      int r;
      r = (t - MINV) % (1 << AW);
      if (r < 0) r += (1 << AW);
      return r + MINV;
   endfunction

   function automatic void model_clear(input int n);
      run_w[n]   = 0;
      run_ovf[n] = 1'b0;
      run_cnt[n] = 0;
   endfunction

   // Reference: exact product, exact running sum, wrap into 11 bits
   function automatic void model_add(input int n, input int a, input int b,
                                     input bit s, input bit l);
      int p;
      int t;
      int cmax;
      cmax = (n == 2) ? 7 : 65535;
      p = a * b;
      if (s) p = -p;
      t = run_w[n] + p;
      if (t > MAXV || t < MINV) run_ovf[n] = 1'b1;
      run_w[n] = wrap(t);
      if (run_cnt[n] < cmax) run_cnt[n]++;
      if (l) begin
         exp_q[n].push_back('{val: run_w[n], ovf: run_ovf[n], cnt: run_cnt[n]});
         model_clear(n);
      end
   endfunction

   task automatic tick(input int n);
      @(posedge clk);
      #1;
      if (rmode[n]) ordy[n] = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input int n, input int a, input int b, input bit s, input bit l);
      int t;
      t = 0;
      a_v[n]   = 4'(a);
      b_v[n]   = 4'(b);
      sub_v[n] = s;
      lst_v[n] = l;
      vld[n]   = 1'b1;
      @(negedge clk);
      while (!rdy[n] && t < 300) begin
         tick(n);
         @(negedge clk);
         t++;
      end
      if (!rdy[n]) begin
         checks++;
         errors++;
         $display("FAIL accept[%0d]: in_ready stuck at %0b", n, rdy[n]);
      end else begin
         model_add(n, a, b, s, l);
      end
      tick(n);
      vld[n] = 1'b0;
   endtask

   task automatic idle(input int n, input int k);
      vld[n] = 1'b0;
      repeat (k) tick(n);
   endtask

   task automatic wait_out(input int n, input int v, input bit f, input int c,
                           input string nm);
      int t;
      t = 0;
      @(negedge clk);
      while (!ov[n] && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!ov[n]) begin
         errors++;
         $display("FAIL %s: out_valid never rose, expected val=%0d", nm, v);
      end else if (o_val[n] != v || oovf[n] != f || o_cnt[n] != c) begin
         errors++;
         $display("FAIL %s: got val=%0d ovf=%0b cnt=%0d, expected val=%0d ovf=%0b cnt=%0d",
                  nm, o_val[n], oovf[n], o_cnt[n], v, f, c);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_held(input string nm);
      checks++;
      if (!(ov[0] && !rdy[0] && o_val[0] == 16 && o_cnt[0] == 1)) begin
         errors++;
         $display("FAIL %s: got out_valid=%0b in_ready=%0b val=%0d cnt=%0d, expected 1 0 16 1",
                  nm, ov[0], rdy[0], o_val[0], o_cnt[0]);
      end
   endtask

   task automatic random_run(input int n, input int frames);
      int len;
      rmode[n] = 1'b1;
      for (int f = 0; f < frames; f++) begin
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle(n, $urandom_range(1, 3));
            send(n, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                 1'($urandom_range(0, 1)), i == len - 1);
         end
      end
      for (int t = 0; t < 3000 && exp_q[n].size() != 0; t++) tick(n);
   endtask

   task automatic directed(input int n);
      send(n, -6, -8, 0, 0);
      send(n, -3, 4, 0, 0);
      send(n, 2, -8, 0, 1);
      wait_out(n, 20, 0, 3, "frame_sum");

      send(n, 4, 4, 1, 0);
      send(n, -2, -8, 0, 1);
      wait_out(n, 0, 0, 2, "subtract");

      for (int i = 0; i < 16; i++) send(n, -8, -8, 0, i == 15);
      wait_out(n, -1024, 1, 16, "overflow");
      send(n, 4, 4, 0, 1);
      wait_out(n, 16, 0, 1, "after_overflow");

      ordy[n] = 1'b0;
      send(n, 4, 4, 0, 1);
      repeat (4) tick(n);
      @(negedge clk);
      check_held("stall_start");
      fork
         begin
            repeat (3) begin
               tick(n);
               @(negedge clk);
               check_held("stall_hold");
            end
            @(posedge clk);
            #1;
            ordy[n] = 1'b1;
         end
         begin
            @(posedge clk);
            #1;
            send(n, 2, 4, 0, 0);
            send(n, -4, 4, 1, 1);
         end
      join
      wait_out(n, 24, 0, 2, "backpressure_second");

      send(n, 4, 4, 0, 0);
      send(n, 4, 4, 0, 0);
      rst_v[n] = 1'b1;
      tick(n);
      rst_v[n] = 1'b0;
      model_clear(n);
      @(negedge clk);
      checks++;
      if (!rdy[n] || ov[n]) begin
         errors++;
         $display("FAIL mid_reset: got in_ready=%0b out_valid=%0b, expected 1 0", rdy[n], ov[n]);
      end
      @(posedge clk);
      #1;
      send(n, 4, 4, 0, 1);
      wait_out(n, 16, 0, 1, "after_reset");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int n = 0; n < 3; n++) begin
         rst_v[n] = 1'b1;
         a_v[n]   = '0;
         b_v[n]   = '0;
         sub_v[n] = 1'b0;
         lst_v[n] = 1'b0;
         vld[n]   = 1'b0;
         ordy[n]  = 1'b1;
         rmode[n] = 1'b0;
         model_clear(n);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) rst_v[n] = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         checks++;
         if (ov[n] !== 1'b0 || o_val[n] != 0 || o_cnt[n] != 0 || oovf[n] !== 1'b0
             || rdy[n] !== 1'b1) begin
            errors++;
            $display("FAIL reset[%0d]: got valid=%0b val=%0d cnt=%0d ovf=%0b ready=%0b",
                     n, ov[n], o_val[n], o_cnt[n], oovf[n], rdy[n]);
         end
      end
      @(posedge clk);
      #1;
      fork
         begin
            directed(0);
            random_run(0, 30);
         end
         random_run(1, 40);
         random_run(2, 40);
      join
      repeat (10) @(posedge clk);
      for (int n = 0; n < 3; n++) begin
         checks++;
         if (exp_q[n].size() != 0 || lat_q[n].size() != 0) begin
            errors++;
            $display("FAIL drain[%0d]: %0d results and %0d lasts outstanding, expected 0",
                     n, exp_q[n].size(), lat_q[n].size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
